// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl: hazard controller for the 5-stage MIPS pipeline.
//   Compares the ID-stage operands against the destinations in EX and MEM.
//   It stalls the front end by holding PC and IF/ID and inserting an ID/EX
//   bubble. It flushes IF/ID on a taken branch and registers the ALU operand
//   forwarding selects. It also keeps a saturating count of stalled cycles.
//
// Build option: define FORWARDING_EN to enable operand forwarding.
//   With FORWARDING_EN, only a load-use hazard stalls, for one cycle.
//   Without FORWARDING_EN, the selects stay at 00. The stall length then
//   depends on producer distance: 2 cycles for EX and 1 cycle for MEM.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] i_id_rt,
    input  logic                      i_id_use_rs,
    input  logic                      i_id_use_rt,
    input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
    input  logic                      i_ex_regwrite,
    input  logic                      i_ex_memread,
    input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
    input  logic                      i_mem_regwrite,
    input  logic                      i_branch_taken,
    output logic                      o_pc_write,
    output logic                      o_ifid_write,
    output logic                      o_idex_bubble,
    output logic                      o_ifid_flush,
    output logic [1:0]                o_fwd_a_sel,
    output logic [1:0]                o_fwd_b_sel,
    output logic [CNT_WIDTH-1:0]      o_stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] SEL_REGFILE = 2'b00;
    localparam logic [1:0] SEL_EXMEM   = 2'b01;
    localparam logic [1:0] SEL_MEMWB   = 2'b10;

    state_t               r_state;
    state_t               w_next_state;
    logic [1:0]           r_cnt;
    logic [1:0]           w_next_cnt;
    logic [1:0]           w_n;
    logic                 w_stall;
    logic                 w_flush;
    logic [1:0]           r_fwd_a_sel;
    logic [1:0]           r_fwd_b_sel;
    logic [CNT_WIDTH-1:0] r_stall_cycles;

    // A reader matches a writer only for a real, non-zero destination.
    function automatic logic f_match(input logic                      use_x,
                                     input logic [REG_ADDR_WIDTH-1:0] x,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic                      we);
        return use_x & we & (rd != '0) & (rd == x);
    endfunction

    logic w_ex_match_a, w_ex_match_b, w_mem_match_a, w_mem_match_b;
    assign w_ex_match_a  = f_match(i_id_use_rs, i_id_rs, i_ex_rd,  i_ex_regwrite);
    assign w_ex_match_b  = f_match(i_id_use_rt, i_id_rt, i_ex_rd,  i_ex_regwrite);
    assign w_mem_match_a = f_match(i_id_use_rs, i_id_rs, i_mem_rd, i_mem_regwrite);
    assign w_mem_match_b = f_match(i_id_use_rt, i_id_rt, i_mem_rd, i_mem_regwrite);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time. Stall one cycle.
    assign w_n = ((w_ex_match_a | w_ex_match_b) & i_ex_memread) ? 2'd1 : 2'd0;
`else
    // Without forwarding, wait until the producer reaches WB.
    // The register file is written in the first half of the WB cycle.
    logic w_unused_memread;
    assign w_unused_memread = i_ex_memread;
    assign w_n = (w_ex_match_a | w_ex_match_b)   ? 2'd2 :
                 (w_mem_match_a | w_mem_match_b) ? 2'd1 : 2'd0;
`endif

    // State register and remaining-stall counter.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_RUN;
            r_cnt   <= 2'd0;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments, so every
            // register samples the values from before the edge.
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Next-state logic: start, count down or end a stall, and enter FLUSH.
    always_comb begin
        // NOTE: set defaults first so that no path leaves a signal unassigned.
        // An unassigned path would infer a latch.
        w_next_state = S_RUN;
        w_next_cnt   = 2'd0;
        case (r_state)
            S_RUN, S_FLUSH: begin
                if (w_n > 2'd1) begin
                    w_next_state = S_STALL;
                    w_next_cnt   = w_n - 2'd1;
                end else if (w_n == 2'd0 && r_state == S_RUN && i_branch_taken) begin
                    w_next_state = S_FLUSH;
                end
            end
            S_STALL: begin
                if (r_cnt != 2'd1) begin
                    w_next_state = S_STALL;
                    w_next_cnt   = r_cnt - 2'd1;
                end
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Output logic. A stall takes priority over a branch. Reset releases the
    // pipeline enables at once.
    always_comb begin
        w_stall = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            S_RUN:   begin
                w_stall = (w_n != 2'd0);
                w_flush = (w_n == 2'd0) & i_branch_taken;
            end
            S_FLUSH: w_stall = (w_n != 2'd0);
            S_STALL: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
        w_stall       = w_stall & ~i_reset;
        w_flush       = w_flush & ~i_reset;
        o_pc_write    = ~w_stall;
        o_ifid_write  = ~w_stall;
        o_idex_bubble = w_stall;
        o_ifid_flush  = w_flush;
    end

    // Forwarding selects. They load on every edge and are cleared for a bubble.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_fwd_a_sel <= SEL_REGFILE;
            r_fwd_b_sel <= SEL_REGFILE;
        end else if (w_stall) begin
            r_fwd_a_sel <= SEL_REGFILE;
            r_fwd_b_sel <= SEL_REGFILE;
        end else begin
`ifdef FORWARDING_EN
            r_fwd_a_sel <= (w_ex_match_a & ~i_ex_memread) ? SEL_EXMEM :
                           w_mem_match_a                  ? SEL_MEMWB : SEL_REGFILE;
            r_fwd_b_sel <= (w_ex_match_b & ~i_ex_memread) ? SEL_EXMEM :
                           w_mem_match_b                  ? SEL_MEMWB : SEL_REGFILE;
`else
            r_fwd_a_sel <= SEL_REGFILE;
            r_fwd_b_sel <= SEL_REGFILE;
`endif
        end
    end

    // Debug counter. It counts stalled cycles and holds at all-ones.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
        end
    end

    assign o_fwd_a_sel    = r_fwd_a_sel;
    assign o_fwd_b_sel    = r_fwd_b_sel;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
//   It uses CNT_WIDTH=4 so that counter saturation is reached quickly.
//   Scenarios that depend on the build follow the FORWARDING_EN define.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int CW  = 4;

    // {pc_write, ifid_write, idex_bubble, ifid_flush}
    localparam logic [3:0] CTL_RUN   = 4'b1100;
    localparam logic [3:0] CTL_STALL = 4'b0010;
    localparam logic [3:0] CTL_FLUSH = 4'b1101;

    logic          i_clock;
    logic          i_reset;
    logic [AW-1:0] i_id_rs, i_id_rt, i_ex_rd, i_mem_rd;
    logic          i_id_use_rs, i_id_use_rt;
    logic          i_ex_regwrite, i_ex_memread, i_mem_regwrite, i_branch_taken;
    logic          o_pc_write, o_ifid_write, o_idex_bubble, o_ifid_flush;
    logic [1:0]    o_fwd_a_sel, o_fwd_b_sel;
    logic [CW-1:0] o_stall_cycles;

    logic [3:0]    ctl;
    assign ctl = {o_pc_write, o_ifid_write, o_idex_bubble, o_ifid_flush};

    int tests_run = 0;
    int tests_failed = 0;
    int exp_cnt = 0;

    hazard_ctrl #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_use_rs    (i_id_use_rs),
        .i_id_use_rt    (i_id_use_rt),
        .i_ex_rd        (i_ex_rd),
        .i_ex_regwrite  (i_ex_regwrite),
        .i_ex_memread   (i_ex_memread),
        .i_mem_rd       (i_mem_rd),
        .i_mem_regwrite (i_mem_regwrite),
        .i_branch_taken (i_branch_taken),
        .o_pc_write     (o_pc_write),
        .o_ifid_write   (o_ifid_write),
        .o_idex_bubble  (o_idex_bubble),
        .o_ifid_flush   (o_ifid_flush),
        .o_fwd_a_sel    (o_fwd_a_sel),
        .o_fwd_b_sel    (o_fwd_b_sel),
        .o_stall_cycles (o_stall_cycles)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Advance to 1 ns after the next rising edge. Inputs are driven here and
    // outputs are sampled 1 ns later, well away from either edge.
    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_inputs();
        i_id_rs = '0; i_id_rt = '0; i_id_use_rs = 1'b0; i_id_use_rt = 1'b0;
        i_ex_rd = '0; i_ex_regwrite = 1'b0; i_ex_memread = 1'b0;
        i_mem_rd = '0; i_mem_regwrite = 1'b0; i_branch_taken = 1'b0;
    endtask

    // The smallest hazard for this build: a load in EX with forwarding, or a
    // producer in MEM without it. Either gives a 1-cycle stall.
    task automatic set_one_cycle_hazard(input logic [AW-1:0] r);
        i_id_rs = r; i_id_use_rs = 1'b1;
`ifdef FORWARDING_EN
        i_ex_rd = r; i_ex_regwrite = 1'b1; i_ex_memread = 1'b1;
`else
        i_mem_rd = r; i_mem_regwrite = 1'b1;
`endif
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 1'b1;
        next_cycle();
        next_cycle();
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        tests_run++;
        if ({o_fwd_a_sel, o_fwd_b_sel} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_sel: got %b expected 0000", {o_fwd_a_sel, o_fwd_b_sel});
        end
        tests_run++;
        if (o_stall_cycles !== 4'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", o_stall_cycles);
        end
        i_reset = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_no_hazard();
        clear_inputs();
        i_id_rs = 5'd3; i_id_use_rs = 1'b1; i_id_rt = 5'd4; i_id_use_rt = 1'b1;
        i_ex_rd = 5'd6; i_ex_regwrite = 1'b1; i_mem_rd = 5'd7; i_mem_regwrite = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL no_hazard_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        next_cycle();
        tests_run++;
        if ({o_fwd_a_sel, o_fwd_b_sel} !== 4'b0000) begin
            tests_failed++; $display("FAIL no_hazard_sel: got %b expected 0000", {o_fwd_a_sel, o_fwd_b_sel});
        end
    endtask

    task automatic test_reg0_and_use();
        // Register 0 never matches.
        clear_inputs();
        i_id_rs = 5'd0; i_id_use_rs = 1'b1; i_ex_rd = 5'd0; i_ex_regwrite = 1'b1;
        i_mem_rd = 5'd0; i_mem_regwrite = 1'b1; i_ex_memread = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL reg0_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        // The operand is not read, so there is no hazard.
        clear_inputs();
        i_id_rs = 5'd5; i_id_use_rs = 1'b0; i_ex_rd = 5'd5; i_ex_regwrite = 1'b1; i_ex_memread = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL unused_operand_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        next_cycle();
    endtask

`ifdef FORWARDING_EN
    task automatic test_load_use();
        clear_inputs();
        i_ex_rd = 5'd8; i_ex_regwrite = 1'b1; i_ex_memread = 1'b1;
        i_id_rs = 5'd8; i_id_use_rs = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL load_use_ctl0: got %b expected %b", ctl, CTL_STALL);
        end
        next_cycle();
        exp_cnt++;
        tests_run++;
        if (o_fwd_a_sel !== 2'b00) begin
            tests_failed++; $display("FAIL load_use_sel: got %b expected 00", o_fwd_a_sel);
        end
        clear_inputs();
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL load_use_ctl1: got %b expected %b", ctl, CTL_RUN);
        end
        tests_run++;
        if (o_stall_cycles !== CW'(exp_cnt)) begin
            tests_failed++; $display("FAIL load_use_cnt: got %0d expected %0d", o_stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        i_ex_rd = 5'd9; i_ex_regwrite = 1'b1; i_mem_rd = 5'd9; i_mem_regwrite = 1'b1;
        i_id_rt = 5'd9; i_id_use_rt = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL fwd_prio_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        next_cycle();
        tests_run++;
        if ({o_fwd_a_sel, o_fwd_b_sel} !== 4'b0001) begin
            tests_failed++; $display("FAIL fwd_prio_ex: got %b expected 0001", {o_fwd_a_sel, o_fwd_b_sel});
        end
        i_ex_rd = 5'd0;
        next_cycle();
        tests_run++;
        if ({o_fwd_a_sel, o_fwd_b_sel} !== 4'b0010) begin
            tests_failed++; $display("FAIL fwd_prio_mem: got %b expected 0010", {o_fwd_a_sel, o_fwd_b_sel});
        end
        clear_inputs();
        next_cycle();
    endtask
`else
    task automatic test_dist_stall();
        clear_inputs();
        i_ex_rd = 5'd5; i_ex_regwrite = 1'b1; i_id_rs = 5'd5; i_id_use_rs = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL dist_ex_ctl0: got %b expected %b", ctl, CTL_STALL);
        end
        next_cycle();
        // The stall holds for its full length even after the hazard inputs go quiet.
        clear_inputs();
        #1;
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL dist_ex_ctl1: got %b expected %b", ctl, CTL_STALL);
        end
        next_cycle();
        exp_cnt += 2;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL dist_ex_ctl2: got %b expected %b", ctl, CTL_RUN);
        end
        tests_run++;
        if ({o_fwd_a_sel, o_fwd_b_sel} !== 4'b0000) begin
            tests_failed++; $display("FAIL dist_ex_sel: got %b expected 0000", {o_fwd_a_sel, o_fwd_b_sel});
        end
        tests_run++;
        if (o_stall_cycles !== CW'(exp_cnt)) begin
            tests_failed++; $display("FAIL dist_ex_cnt: got %0d expected %0d", o_stall_cycles, exp_cnt);
        end
        // A producer in MEM gives a 1-cycle stall on rt.
        i_mem_rd = 5'd7; i_mem_regwrite = 1'b1; i_id_rt = 5'd7; i_id_use_rt = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL dist_mem_ctl0: got %b expected %b", ctl, CTL_STALL);
        end
        next_cycle();
        exp_cnt++;
        clear_inputs();
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL dist_mem_ctl1: got %b expected %b", ctl, CTL_RUN);
        end
        tests_run++;
        if (o_stall_cycles !== CW'(exp_cnt)) begin
            tests_failed++; $display("FAIL dist_mem_cnt: got %0d expected %0d", o_stall_cycles, exp_cnt);
        end
    endtask
`endif

    task automatic test_branch_flush();
        clear_inputs();
        i_branch_taken = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_FLUSH) begin
            tests_failed++; $display("FAIL branch_flush0: got %b expected %b", ctl, CTL_FLUSH);
        end
        next_cycle();
        // In FLUSH there is no second flush, even though the branch is still high.
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL branch_flush1: got %b expected %b", ctl, CTL_RUN);
        end
        i_branch_taken = 1'b0;
        next_cycle();
    endtask

    task automatic test_branch_with_hazard();
        clear_inputs();
        set_one_cycle_hazard(5'd8);
        i_branch_taken = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL branch_hazard_ctl0: got %b expected %b", ctl, CTL_STALL);
        end
        next_cycle();
        exp_cnt++;
        clear_inputs();
        i_branch_taken = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_FLUSH) begin
            tests_failed++; $display("FAIL branch_hazard_ctl1: got %b expected %b", ctl, CTL_FLUSH);
        end
        tests_run++;
        if (o_stall_cycles !== CW'(exp_cnt)) begin
            tests_failed++; $display("FAIL branch_hazard_cnt: got %0d expected %0d", o_stall_cycles, exp_cnt);
        end
        next_cycle();
        i_branch_taken = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
`ifdef FORWARDING_EN
        set_one_cycle_hazard(5'd5);
        #1;
`else
        // This EX hazard is 2 cycles long. The edge puts the FSM into STALL.
        i_ex_rd = 5'd5; i_ex_regwrite = 1'b1; i_id_rs = 5'd5; i_id_use_rs = 1'b1;
        next_cycle();
`endif
        i_reset = 1'b1;
        #1;
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL reset_mid_ctl: got %b expected %b", ctl, CTL_RUN);
        end
        tests_run++;
        if (o_stall_cycles !== 4'd0) begin
            tests_failed++; $display("FAIL reset_mid_cnt: got %0d expected 0", o_stall_cycles);
        end
        next_cycle();
        clear_inputs();
        i_reset = 1'b0;
        exp_cnt = 0;
        next_cycle();
        tests_run++;
        if (ctl !== CTL_RUN) begin
            tests_failed++; $display("FAIL reset_mid_state: got %b expected %b", ctl, CTL_RUN);
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        set_one_cycle_hazard(5'd12);
        // Hold the hazard for 2^4+3 = 19 stalled cycles.
        for (int i = 0; i < (1 << CW) + 3; i++) next_cycle();
        tests_run++;
        if (o_stall_cycles !== 4'd15) begin
            tests_failed++; $display("FAIL saturate_cnt: got %0d expected 15", o_stall_cycles);
        end
        tests_run++;
        if (ctl !== CTL_STALL) begin
            tests_failed++; $display("FAIL saturate_ctl: got %b expected %b", ctl, CTL_STALL);
        end
        clear_inputs();
        next_cycle();
        tests_run++;
        if (o_stall_cycles !== 4'd15) begin
            tests_failed++; $display("FAIL saturate_hold: got %0d expected 15", o_stall_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_no_hazard();
        test_reg0_and_use();
`ifdef FORWARDING_EN
        test_load_use();
        test_fwd_priority();
`else
        test_dist_stall();
`endif
        test_branch_flush();
        test_branch_with_hazard();
        test_reset_mid_stall();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
